hazard_ctrl_unit: RTL
=====================

Name: hazard_ctrl_unit

Overview:
Pipeline hazard controller for the 5-stage MIPS core (IF/ID/EX/MEM/WB) with branch/jump resolved in MEM. Generates EX operand forwarding selects, load-use stalls, multi-cycle EX stalls with handshake, and redirect flushes. Also keeps saturating performance counters. Sits beside the BF0..BF3 pipeline registers and drives their enable/flush inputs plus the PC enable.

Parameters:
REG_AW, 5, register address width
FWD_EN, 1, 1 = forwarding on; 0 = forwarding off, stall on any RAW against EX/MEM destination
MULTI_TIMEOUT, 64, cycles in MULTI before multi_err is set
CNT_W, 32, width of the performance counters

Ports:
clk_CPU  in  1  clock
rst_CPU_n  in  1  synchronous reset, active-low
id_rs, id_rt  in  REG_AW  source registers of the instruction in ID
id_uses_rs, id_uses_rt  in  1  ID instruction reads rs/rt
ex_rs, ex_rt, ex_rd  in  REG_AW  EX sources / destination (post RegDst mux)
ex_regwrite, ex_memread  in  1  EX control bits
mem_rd, wb_rd  in  REG_AW  destinations in MEM/WB
mem_regwrite, wb_regwrite  in  1  write enables in MEM/WB
wb_valid  in  1  real (non-bubble) instruction in WB
mem_redirect  in  1  taken branch or jump resolved in MEM
ex_multi_req  in  1  level; multi-cycle op occupies EX
ex_multi_done  in  1  multi-cycle unit result valid this cycle
fwd_a, fwd_b  out  2  EX operand select: 00 = register file, 01 = WB, 10 = MEM
pc_en, if_id_en, id_ex_en  out  1  stage register enables
if_id_flush, id_ex_flush, ex_mem_flush  out  1  load a bubble (control bits zeroed)
multi_abort  out  1  one-cycle pulse: multi op killed by redirect
multi_err  out  1  sticky timeout flag
stall_cnt, flush_cnt, retire_cnt  out  CNT_W  saturating counters

Behaviour:
- Reset (rst_CPU_n=0 at clock edge): FSM state goes to RUN; counters and multi_err are set to 0.
- While rst_CPU_n=0, outputs are forced: enables=0, all flushes=1, fwd=00, multi_abort=0.
- FSM has two states: RUN and MULTI. Outputs are combinational from the current state and inputs (zero latency). The FSM and counters are registered.
- Forwarding (FWD_EN=1):
  - fwd_a=10 if mem_regwrite && mem_rd!=0 && mem_rd==ex_rs.
  - Else fwd_a=01 if wb_regwrite && wb_rd!=0 && wb_rd==ex_rs.
  - Else fwd_a=00.
  - fwd_b is identical using ex_rt.
  - MEM beats WB when both match.
- With FWD_EN=0, fwd_a and fwd_b are tied to 00.
- RAW(x) is defined as: x!=0 && ((id_uses_rs && id_rs==x) || (id_uses_rt && id_rt==x)).
- Hazard stall condition:
  - FWD_EN=1: ex_memread && ex_regwrite && RAW(ex_rd).
  - FWD_EN=0: (ex_regwrite && RAW(ex_rd)) || (mem_regwrite && RAW(mem_rd)).
  - The register bank is write-before-read, so WB needs no stall.
- Hazard stall response: pc_en=0, if_id_en=0, id_ex_flush=1, id_ex_en=1.
- Transitions and priority, highest first:
  - RUN, mem_redirect=1: if_id_flush, id_ex_flush and ex_mem_flush all =1; pc_en=1. Any concurrent hazard or multi request is ignored. Stay in RUN.
  - RUN, ex_multi_req=1 && ex_multi_done=0: pc_en, if_id_en and id_ex_en =0; ex_mem_flush=1. Next state MULTI. A concurrent hazard stall is subsumed.
  - RUN, ex_multi_req && ex_multi_done: no stall; the op completes like a single-cycle op.
  - RUN, hazard stall: as defined above.
  - RUN, otherwise: all enables=1, all flushes=0.
  - MULTI, mem_redirect=1: flush as in RUN; multi_abort=1; next state RUN.
  - MULTI, ex_multi_done=1: enables=1, ex_mem_flush=0 (result captured). Any hazard stall is evaluated normally this cycle. Next state RUN.
  - MULTI, otherwise: freeze (pc_en, if_id_en, id_ex_en =0; ex_mem_flush=1).
- Timeout counter:
  - Counts cycles in MULTI; cleared on entry to MULTI.
  - When the count reaches MULTI_TIMEOUT, multi_err is set to 1 and stays set until reset.
  - The FSM keeps waiting for ex_multi_done.
- Performance counters (all saturate at all-ones, no wrap):
  - stall_cnt: +1 each cycle with pc_en=0, reset excluded.
  - flush_cnt: +1 each cycle with mem_redirect=1.
  - retire_cnt: +1 each cycle with wb_valid=1.
- Reset asserted mid-MULTI: the FSM returns to RUN on that edge and no multi_abort pulse is produced.

Decomposition:
- Package hazard_pkg holds:
  - state enum {ST_RUN, ST_MULTI};
  - forwarding select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- One sub-module, sat_counter (params W; inputs clk_CPU, rst_CPU_n, inc; output count), instantiated three times.
- Forwarding and hazard logic stay inline.

Test Plan:
- Forwarding priority: ex_rs=3 with mem_rd=3/mem_regwrite=1 and wb_rd=3/wb_regwrite=1 -> fwd_a=10. Drop mem_regwrite -> fwd_a=01. Set ex_rs=0 -> fwd_a=00.
- Load-use: ex_memread=1, ex_regwrite=1, ex_rd=5, id_rs=5, id_uses_rs=1 -> exactly one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt becomes 1.
- Multi-cycle: ex_multi_req=1 with done arriving 4 cycles later -> 4 freeze cycles with ex_mem_flush=1; on the done cycle enables=1 and ex_mem_flush=0; next state RUN.
- Redirect during MULTI: mem_redirect=1 on the 2nd MULTI cycle -> all three flushes=1, multi_abort pulses once, state returns to RUN, flush_cnt increments by 1.
- Simultaneous events: mem_redirect=1 together with a load-use hazard -> pc_en=1, all flushes=1, stall_cnt unchanged. Separately, hold MULTI for 64 cycles -> multi_err=1 and stays set after done.
- Reset and saturation: assert rst_CPU_n=0 mid-MULTI -> next state RUN, counters 0. With CNT_W=4, 20 wb_valid cycles -> retire_cnt=15.

Source files
------------

// File: rtl/hazard_ctrl_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard controller.
//   state_e   : controller FSM states (normal flow / multi-cycle EX wait)
//   FWD_*     : EX operand forwarding select encodings
// -----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_MULTI = 1'b1
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from WB stage result
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from MEM stage result

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit_if
// Bundle between the pipeline datapath and the hazard controller.
//   master : pipeline side - drives stage register/control info, consumes
//            forwarding selects, enables, flushes, status and counters
//   slave  : hazard controller side
// Parameters: REG_AW register address width, CNT_W performance counter width.
// -----------------------------------------------------------------------------
interface hazard_ctrl_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);

  // ID stage
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  // EX stage
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_regwrite;
  logic              ex_memread;
  logic              ex_multi_req;
  logic              ex_multi_done;
  // MEM / WB stages
  logic [REG_AW-1:0] mem_rd;
  logic [REG_AW-1:0] wb_rd;
  logic              mem_regwrite;
  logic              wb_regwrite;
  logic              wb_valid;
  logic              mem_redirect;

  // Controller outputs
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              pc_en;
  logic              if_id_en;
  logic              id_ex_en;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic              ex_mem_flush;
  logic              multi_abort;
  logic              multi_err;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  logic [CNT_W-1:0]  retire_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt,
           ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread,
           ex_multi_req, ex_multi_done,
           mem_rd, wb_rd, mem_regwrite, wb_regwrite, wb_valid, mem_redirect,
    input  fwd_a, fwd_b, pc_en, if_id_en, id_ex_en,
           if_id_flush, id_ex_flush, ex_mem_flush,
           multi_abort, multi_err, stall_cnt, flush_cnt, retire_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt,
           ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread,
           ex_multi_req, ex_multi_done,
           mem_rd, wb_rd, mem_regwrite, wb_regwrite, wb_valid, mem_redirect,
    output fwd_a, fwd_b, pc_en, if_id_en, id_ex_en,
           if_id_flush, id_ex_flush, ex_mem_flush,
           multi_abort, multi_err, stall_cnt, flush_cnt, retire_cnt
  );

endinterface

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// W-bit event counter that sticks at all-ones instead of wrapping.
//   clk_CPU   : clock
//   rst_CPU_n : synchronous active-low reset, clears the count
//   inc       : count one event this cycle
//   count     : current value
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_CPU,
  input  logic         rst_CPU_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk_CPU) begin
    if (!rst_CPU_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit
// Hazard controller for the 5-stage MIPS pipeline (branches resolve in MEM).
// Produces EX forwarding selects, load-use / no-forwarding RAW stalls,
// multi-cycle EX freeze with a done handshake, redirect flushes, a sticky
// multi-cycle timeout flag and three saturating performance counters.
//
// Ports:
//   clk_CPU    : clock
//   rst_CPU_n  : synchronous active-low reset; while low, all stage enables
//                are 0, all flushes are 1 and forwarding selects read the RF
//   hz (slave) : pipeline bundle, see hazard_ctrl_unit_if
//
// Parameters:
//   REG_AW        register address width (must match the interface)
//   FWD_EN        1 = forwarding network present, 0 = stall on any RAW
//                 against the EX or MEM destination
//   MULTI_TIMEOUT cycles spent waiting in MULTI before multi_err sets
//   CNT_W         performance counter width (must match the interface)
// -----------------------------------------------------------------------------
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW        = 5,
  parameter int FWD_EN        = 1,
  parameter int MULTI_TIMEOUT = 64,
  parameter int CNT_W         = 32
) (
  input logic             clk_CPU,
  input logic             rst_CPU_n,
  hazard_ctrl_unit_if.slave hz
);

  localparam bit FWD_ON = (FWD_EN != 0);
  localparam int TMO_W  = $clog2(MULTI_TIMEOUT + 1);
  // The err flag sets on the edge that closes the MULTI_TIMEOUT-th MULTI cycle.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MULTI_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(MULTI_TIMEOUT);

  state_e            state;
  state_e            state_nxt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              multi_err_q;

  logic              raw_ex;
  logic              raw_mem;
  logic              hazard;

  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              pc_en;
  logic              if_id_en;
  logic              id_ex_en;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic              ex_mem_flush;
  logic              multi_abort;

  // Forwarding source for one EX operand; MEM holds the younger result so it
  // wins when both stages target the same register. r0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] mem_rd,
    input logic              mem_we,
    input logic [REG_AW-1:0] wb_rd,
    input logic              wb_we
  );
    if (mem_we && (mem_rd != '0) && (mem_rd == src)) return FWD_MEM;
    if (wb_we  && (wb_rd  != '0) && (wb_rd  == src)) return FWD_WB;
    return FWD_RF;
  endfunction

  // True when the ID instruction reads register x (x != r0).
  function automatic logic raw_hit(
    input logic [REG_AW-1:0] x,
    input logic [REG_AW-1:0] rs,
    input logic              uses_rs,
    input logic [REG_AW-1:0] rt,
    input logic              uses_rt
  );
    return (x != '0) && ((uses_rs && (rs == x)) || (uses_rt && (rt == x)));
  endfunction

  assign raw_ex  = raw_hit(hz.ex_rd,  hz.id_rs, hz.id_uses_rs, hz.id_rt, hz.id_uses_rt);
  assign raw_mem = raw_hit(hz.mem_rd, hz.id_rs, hz.id_uses_rs, hz.id_rt, hz.id_uses_rt);

  // With forwarding only a load in EX needs a bubble; without it, any pending
  // write in EX or MEM blocks ID. The register file writes before it reads,
  // so a WB producer never stalls.
  assign hazard = FWD_ON ? (hz.ex_memread && hz.ex_regwrite && raw_ex)
                         : ((hz.ex_regwrite && raw_ex) || (hz.mem_regwrite && raw_mem));

  // ---------------------------------------------------------------------------
  // Combinational control outputs and next state
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default at the top of the block so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    fwd_a        = FWD_RF;
    fwd_b        = FWD_RF;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    multi_abort  = 1'b0;

    if (!rst_CPU_n) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else begin
      if (FWD_ON) begin
        fwd_a = fwd_sel(hz.ex_rs, hz.mem_rd, hz.mem_regwrite, hz.wb_rd, hz.wb_regwrite);
        fwd_b = fwd_sel(hz.ex_rt, hz.mem_rd, hz.mem_regwrite, hz.wb_rd, hz.wb_regwrite);
      end

      unique case (state)
        ST_RUN: begin
          if (hz.mem_redirect) begin
            // Wrong-path instructions in IF/ID/EX are squashed; fetch the target.
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
          end else if (hz.ex_multi_req && !hz.ex_multi_done) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
            state_nxt    = ST_MULTI;
          end else if (hazard) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end

        ST_MULTI: begin
          if (hz.mem_redirect) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            multi_abort  = 1'b1;
            state_nxt    = ST_RUN;
          end else if (hz.ex_multi_done) begin
            // Result is captured into EX/MEM; ID may still need a bubble.
            state_nxt = ST_RUN;
            if (hazard) begin
              pc_en       = 1'b0;
              if_id_en    = 1'b0;
              id_ex_flush = 1'b1;
            end
          end else begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
          end
        end

        default: state_nxt = ST_RUN;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM, timeout counter and sticky error
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_CPU) begin
    if (!rst_CPU_n) begin
      state       <= ST_RUN;
      tmo_cnt     <= '0;
      multi_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      // Held at zero in RUN, so every entry into MULTI starts from zero.
      if (state != ST_MULTI) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt != TMO_MAX) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if ((state == ST_MULTI) && (tmo_cnt == TMO_LAST)) begin
        multi_err_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_CPU   (clk_CPU),
    .rst_CPU_n (rst_CPU_n),
    .inc       (!pc_en && rst_CPU_n),
    .count     (hz.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_CPU   (clk_CPU),
    .rst_CPU_n (rst_CPU_n),
    .inc       (hz.mem_redirect),
    .count     (hz.flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk_CPU   (clk_CPU),
    .rst_CPU_n (rst_CPU_n),
    .inc       (hz.wb_valid),
    .count     (hz.retire_cnt)
  );

  assign hz.fwd_a        = fwd_a;
  assign hz.fwd_b        = fwd_b;
  assign hz.pc_en        = pc_en;
  assign hz.if_id_en     = if_id_en;
  assign hz.id_ex_en     = id_ex_en;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_flush  = id_ex_flush;
  assign hz.ex_mem_flush = ex_mem_flush;
  assign hz.multi_abort  = multi_abort;
  assign hz.multi_err    = multi_err_q;

endmodule
